mem_fill_arbiter: RTL and testbench

Sequences the single shared, pipelined main-memory port between the I-cache and the write-through D-cache. It arbitrates I-cache miss fills, D-cache miss fills and D-cache store write-throughs. For a fill it issues the 8 word reads of a 16-byte block, steers the returned words into the requesting cache's data array and writes the tag on the last word. It holds the corresponding pipeline stall asserted until the access completes. It sits between the two cache controllers and the main memory model, beside the decode/control unit.

---
 rtl/mem_fill_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
// Shared main-memory port sequencer: arbitrates I/D cache block fills and
// D-cache store write-throughs, steering returned words into the owning cache.
module mem_fill_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WORDS       = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imiss,
  input  logic [ADDR_W-1:0] imiss_addr,
  input  logic              dmiss,
  input  logic [ADDR_W-1:0] dmiss_addr,
  input  logic              dwrite_req,
  input  logic [ADDR_W-1:0] dwrite_addr,
  input  logic [DATA_W-1:0] dwrite_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fill_i,
  output logic              fill_d,
  output logic              fill_tag_i,
  output logic              fill_tag_d,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_stall,
  output logic              d_stall,
  output logic              busy
);

  localparam int CW = $clog2(WORDS);
  localparam int OB = CW + 1;
  localparam logic [CW:0]   ISSUE_END = (CW+1)'(WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  typedef enum logic {OWN_D, OWN_I} owner_t;

  state_t                state;
  owner_t                owner;
  logic [ADDR_W-OB-1:0]  blk;
  logic [CW:0]           issue_cnt;
  logic [CW-1:0]         rcv_cnt;
  logic [MEM_LATENCY-1:0] rd_pipe;
  logic                  take;
  logic                  last;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{imiss_addr[OB-1:0], dmiss_addr[OB-1:0]};

  // Returns are accepted only when a read of ours was issued MEM_LATENCY
  // cycles earlier, so reads left in flight across a reset are dropped.
  assign take = (state == FILL) & mem_valid & rd_pipe[MEM_LATENCY-1];
  assign last = (rcv_cnt == LAST_WORD);

  // mem_en/mem_addr are registered, so the first read is launched from the
  // grant edge and issue_cnt runs one word ahead of the word on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_D;
      blk       <= '0;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      rd_pipe   <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | MEM_LATENCY'(mem_en & ~mem_wr);
      case (state)
        IDLE: begin
          mem_en    <= 1'b0;
          mem_wr    <= 1'b0;
          issue_cnt <= '0;
          rcv_cnt   <= '0;
          if (dmiss) begin
            owner     <= OWN_D;
            blk       <= dmiss_addr[ADDR_W-1:OB];
            mem_addr  <= {dmiss_addr[ADDR_W-1:OB], {OB{1'b0}}};
            mem_en    <= 1'b1;
            issue_cnt <= (CW+1)'(1);
            state     <= FILL;
          end else if (dwrite_req) begin
            owner     <= OWN_D;
            mem_addr  <= dwrite_addr;
            mem_wdata <= dwrite_data;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b1;
            state     <= WRITE;
          end else if (imiss) begin
            owner     <= OWN_I;
            blk       <= imiss_addr[ADDR_W-1:OB];
            mem_addr  <= {imiss_addr[ADDR_W-1:OB], {OB{1'b0}}};
            mem_en    <= 1'b1;
            issue_cnt <= (CW+1)'(1);
            state     <= FILL;
          end
        end
        FILL: begin
          if (issue_cnt < ISSUE_END) begin
            mem_en    <= 1'b1;
            mem_addr  <= {blk, issue_cnt[CW-1:0], 1'b0};
            issue_cnt <= issue_cnt + (CW+1)'(1);
          end else begin
            mem_en <= 1'b0;
          end
          if (take) begin
            rcv_cnt <= rcv_cnt + CW'(1);
            if (last) begin
              mem_en <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        WRITE: begin
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fill_i     = take & (owner == OWN_I);
  assign fill_d     = take & (owner == OWN_D);
  assign fill_tag_i = fill_i & last;
  assign fill_tag_d = fill_d & last;
  assign fill_addr  = {blk, rcv_cnt, 1'b0};
  assign fill_data  = take ? mem_rdata : '0;
  assign busy       = (state != IDLE);
  assign i_stall    = imiss | ((state == FILL) & (owner == OWN_I));
  assign d_stall    = dmiss | dwrite_req | ((state != IDLE) & (owner == OWN_D));

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Randomized bench for mem_fill_arbiter against a transaction-timeline model
// and a fixed-latency memory that keeps running across reset.
module tb_mem_fill_arbiter;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imiss, dmiss, dwrite_req;
  logic [15:0] imiss_addr, dmiss_addr, dwrite_addr, dwrite_data;
  logic        mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        fill_i, fill_d, fill_tag_i, fill_tag_d;
  logic [15:0] fill_addr, fill_data;
  logic        i_stall, d_stall, busy;

  mem_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .MEM_LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .imiss(imiss), .imiss_addr(imiss_addr),
    .dmiss(dmiss), .dmiss_addr(dmiss_addr),
    .dwrite_req(dwrite_req), .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .fill_i(fill_i), .fill_d(fill_d), .fill_tag_i(fill_tag_i), .fill_tag_d(fill_tag_d),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .i_stall(i_stall), .d_stall(d_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory: a read accepted at an edge returns LAT cycles later; data = addr ^ salt.
  logic [15:0]    salt = 16'h0;
  logic           junk = 1'b0;
  logic [LAT-1:0] dl_v = '0;
  logic [15:0]    dl_a [LAT];
  always @(posedge clk) begin
    dl_v     <= {dl_v[LAT-2:0], mem_en & ~mem_wr};
    dl_a[0]  <= mem_addr;
    for (int i = 1; i < LAT; i++) dl_a[i] <= dl_a[i-1];
  end
  assign mem_valid = dl_v[LAT-1] | junk;
  assign mem_rdata = dl_a[LAT-1] ^ salt;

  typedef enum {K_NONE, K_FILL, K_WRITE} kind_t;
  kind_t       kind = K_NONE;
  int          pc = 0, g = 0, k = 0, srv = 0;
  logic        own_i = 1'b0;
  logic [15:0] base = '0, wa = '0, wd = '0;
  bit          rand_on = 1'b0;
  int          n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, pc);
    end
  endtask

  task automatic compare();
    logic        en, wr, fs, last;
    int          j;
    logic [15:0] a;
    if (rst) begin
      check("rst_mem_en", mem_en, 0);      check("rst_mem_wr", mem_wr, 0);
      check("rst_mem_addr", mem_addr, 0);  check("rst_mem_wdata", mem_wdata, 0);
      check("rst_fill_i", fill_i, 0);      check("rst_fill_d", fill_d, 0);
      check("rst_tag_i", fill_tag_i, 0);   check("rst_tag_d", fill_tag_d, 0);
      check("rst_fill_addr", fill_addr, 0); check("rst_fill_data", fill_data, 0);
      check("rst_busy", busy, 0);
      check("rst_i_stall", i_stall, imiss);
      check("rst_d_stall", d_stall, dmiss | dwrite_req);
      return;
    end
    en   = (kind == K_FILL && k >= 1 && k <= 8) || (kind == K_WRITE && k == 1);
    wr   = (kind == K_WRITE && k == 1);
    fs   = (kind == K_FILL && k >= LAT + 1 && k <= LAT + 8);
    j    = k - LAT - 1;
    last = fs && (j == 7);
    check("mem_en", mem_en, en);
    check("mem_wr", mem_wr, wr);
    if (en) begin
      a = (kind == K_FILL) ? 16'(base + 2 * (k - 1)) : wa;
      check("mem_addr", mem_addr, a);
    end
    if (wr) check("mem_wdata", mem_wdata, wd);
    check("fill_i", fill_i, fs & own_i);
    check("fill_d", fill_d, fs & ~own_i);
    check("fill_tag_i", fill_tag_i, last & own_i);
    check("fill_tag_d", fill_tag_d, last & ~own_i);
    if (fs) begin
      a = 16'(base + 2 * j);
      check("fill_addr", fill_addr, a);
      check("fill_data", fill_data, a ^ salt);
    end
    check("busy", busy, kind != K_NONE);
    check("i_stall", i_stall, imiss | (kind == K_FILL && own_i));
    check("d_stall", d_stall, dmiss | dwrite_req | (kind != K_NONE && !own_i));
  endtask

  task automatic drop(input int line);
    if (line == 1) dmiss = 1'b0;
    if (line == 2) dwrite_req = 1'b0;
    if (line == 3) imiss = 1'b0;
  endtask

  // Called at a falling edge: arbitrate for the coming edge, advance one
  // cycle, then check the new cycle and retire served requests.
  task automatic tick();
    kind_t cur;
    cur = kind;
    if (!rst && kind == K_NONE) begin
      if (dmiss) begin
        kind = K_FILL; own_i = 1'b0; base = dmiss_addr & 16'hFFF0; srv = 1; g = pc;
      end else if (dwrite_req) begin
        kind = K_WRITE; own_i = 1'b0; wa = dwrite_addr; wd = dwrite_data; srv = 2; g = pc;
      end else if (imiss) begin
        kind = K_FILL; own_i = 1'b1; base = imiss_addr & 16'hFFF0; srv = 3; g = pc;
      end
    end
    junk = rand_on && !rst && cur != K_FILL && kind != K_FILL && ($urandom_range(0, 2) == 0);
    @(posedge clk);
    pc++;
    @(negedge clk);
    k = pc - g;
    if ((kind == K_FILL && k > 8 + LAT) || (kind == K_WRITE && k > 1)) begin
      kind = K_NONE; srv = 0;
    end
    compare();
    if ((kind == K_FILL && k == 8 + LAT) || (kind == K_WRITE && k == 1)) drop(srv);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((kind != K_NONE || dmiss || imiss || dwrite_req) && n < 100) begin
      tick(); n++;
    end
    check("drain_timeout", n >= 100, 0);
    tick();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 compare();
    kind = K_NONE; srv = 0;
    tick();
    tick();
    imiss_addr = 16'h4000;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; imiss = 0; dmiss = 0; dwrite_req = 0;
    imiss_addr = '0; dmiss_addr = '0; dwrite_addr = '0; dwrite_data = '0;
    salt = 16'($urandom);
    #1 compare();
    tick(); tick();
    rst = 1'b0;
    tick();

    imiss = 1; imiss_addr = 16'h1234;
    drain();

    imiss = 1; imiss_addr = 16'h0100; dmiss = 1; dmiss_addr = 16'h2000;
    drain();

    dwrite_req = 1; dwrite_addr = 16'h0040; dwrite_data = 16'hBEEF;
    drain();

    dmiss = 1; dmiss_addr = 16'h3008;
    dwrite_req = 1; dwrite_addr = 16'h0050; dwrite_data = 16'h1357;
    drain();

    imiss = 1; imiss_addr = 16'h5550;
    n = 0;
    while (!(kind == K_FILL && k == LAT + 3) && n < 40) begin
      tick(); n++;
    end
    check("reset_wait_timeout", n >= 40, 0);
    do_reset();
    drain();

    dmiss = 1; dmiss_addr = 16'hFFF0;
    drain();

    rand_on = 1'b1;
    for (int c = 0; c < 900; c++) begin
      if (!dmiss && !(kind != K_NONE && srv == 1) && $urandom_range(0, 9) == 0) begin
        dmiss = 1; dmiss_addr = 16'($urandom);
      end
      if (!dwrite_req && !(kind != K_NONE && srv == 2) && $urandom_range(0, 9) == 0) begin
        dwrite_req = 1; dwrite_addr = 16'($urandom); dwrite_data = 16'($urandom);
      end
      if (!imiss && !(kind != K_NONE && srv == 3) && $urandom_range(0, 9) == 0) begin
        imiss = 1; imiss_addr = 16'($urandom);
      end
      if (kind != K_NONE && $urandom_range(0, 19) == 0) drop(srv);
      tick();
    end
    rand_on = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", pc);
    $fatal(1, "watchdog");
  end

endmodule
